// File: rtl/exec_sequencer.sv
// exec_sequencer: single-issue instruction sequencer. It latches one instruction,
// steps through the ALU, MUL/DIV, memory or branch sequence for it, and then
// returns to IDLE to accept the next one.
// Optional build macro EXEC_SEQ_PERF_CNT_EN adds the retired and stall counters.
module exec_sequencer #(
  parameter int DATAWIDTH   = 32,
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  input  logic [DATAWIDTH-1:0] instr_i,
  output logic                 instr_ready_o,
  output logic                 alu_en_o,
  output logic [3:0]           alu_op_o,
  output logic [4:0]           ra_o,
  output logic [4:0]           rb_o,
  output logic [4:0]           rd_o,
  output logic                 rf_we_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [12:0]          offset_o,
  input  logic                 mem_ack_i,
  input  logic                 br_taken_i,
  output logic                 pc_load_o,
  output logic                 illegal_o,
  output logic                 timeout_o,
`ifdef EXEC_SEQ_PERF_CNT_EN
  output logic [31:0]          retired_cnt_o,
  output logic [31:0]          stall_cnt_o,
`endif
  output logic                 busy_o
);

  // Opcode map. Codes 12..15 are unassigned and treated as illegal.
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_MUL = 4'd5,  OP_DIV = 4'd6,  OP_LW  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8,  OP_BEQ = 4'd9,  OP_BGT = 4'd10, OP_BGE = 4'd11;

  typedef struct packed {
    logic [12:0] offset;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [3:0]  op;
  } instr_t;

  typedef enum logic [2:0] {IDLE, EXEC, MULDIV, MEM, BRANCH} state_t;

  state_t     state, nxt;
  instr_t     ir;
  instr_t     in_ins;
  logic [7:0] cnt;
  logic       hs, md_last, mem_last, is_alu;

  assign in_ins   = instr_t'(instr_i);
  assign hs       = instr_valid_i && (state == IDLE);
  assign md_last  = (cnt == 8'(MD_LATENCY - 1));
  assign mem_last = (cnt == 8'(MEM_TIMEOUT - 1));
  assign is_alu   = (ir.op <= OP_XOR);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= nxt;
  end

  // Instruction latch on handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni)  ir <= '0;
    else if (hs)  ir <= in_ins;
  end

  // Cycles spent in the current non-IDLE state (MUL/DIV latency, memory timeout)
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state == IDLE) cnt <= '0;
    else                          cnt <= cnt + 8'd1;
  end

  // Next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (hs) begin
        case (in_ins.op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: nxt = EXEC;
          OP_MUL, OP_DIV:                        nxt = MULDIV;
          OP_LW, OP_SW:                          nxt = MEM;
          OP_BEQ, OP_BGT, OP_BGE:                nxt = BRANCH;
          default:                               nxt = EXEC;  // illegal pulses from EXEC
        endcase
      end
      EXEC:    nxt = IDLE;
      BRANCH:  nxt = IDLE;
      MULDIV:  if (md_last) nxt = IDLE;
      MEM:     if (mem_ack_i || mem_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs; single-cycle strobes are masked by rst_ni so a reset aborts them
  always_comb begin
    instr_ready_o = (state == IDLE);
    busy_o        = (state != IDLE);
    alu_op_o      = busy_o ? ir.op     : 4'd0;
    ra_o          = busy_o ? ir.ra     : 5'd0;
    rb_o          = busy_o ? ir.rb     : 5'd0;
    rd_o          = busy_o ? ir.rd     : 5'd0;
    offset_o      = busy_o ? ir.offset : 13'd0;
    alu_en_o      = 1'b0;
    rf_we_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    pc_load_o     = 1'b0;
    illegal_o     = 1'b0;
    timeout_o     = 1'b0;
    case (state)
      EXEC: begin
        alu_en_o  = is_alu;
        rf_we_o   = is_alu && rst_ni;
        illegal_o = !is_alu && rst_ni;
      end
      MULDIV: begin
        alu_en_o = 1'b1;
        rf_we_o  = md_last && rst_ni;
      end
      MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (ir.op == OP_SW);
        if (ir.op == OP_LW) rd_o = ir.rb;  // load destination comes from the rb field
        rf_we_o   = mem_ack_i && (ir.op == OP_LW) && rst_ni;
        timeout_o = !mem_ack_i && mem_last && rst_ni;
      end
      BRANCH:  pc_load_o = br_taken_i && rst_ni;
      default: ;
    endcase
  end

`ifdef EXEC_SEQ_PERF_CNT_EN
  logic done;
  assign done = (state == EXEC && is_alu) || (state == MULDIV && md_last) ||
                (state == MEM && mem_ack_i) || (state == BRANCH);

  // Retired-instruction and stall counters, wrapping naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retired_cnt_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (done)                            retired_cnt_o <= retired_cnt_o + 32'd1;
      if (instr_valid_i && !instr_ready_o) stall_cnt_o   <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: reset, ALU, MUL, LW/SW, memory timeout,
// branches, illegal opcode and mid-operation reset.
module tb_exec_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_ni, instr_valid_i, mem_ack_i, br_taken_i;
  logic [31:0] instr_i;
  logic        instr_ready_o, alu_en_o, rf_we_o, mem_req_o, mem_we_o;
  logic        pc_load_o, illegal_o, timeout_o, busy_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  ra_o, rb_o, rd_o;
  logic [12:0] offset_o;
`ifdef EXEC_SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt_o, stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  exec_sequencer #(.DATAWIDTH(32), .MD_LATENCY(4), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(instr_ready_o), .alu_en_o(alu_en_o), .alu_op_o(alu_op_o),
    .ra_o(ra_o), .rb_o(rb_o), .rd_o(rd_o), .rf_we_o(rf_we_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .offset_o(offset_o),
    .mem_ack_i(mem_ack_i), .br_taken_i(br_taken_i), .pc_load_o(pc_load_o),
    .illegal_o(illegal_o), .timeout_o(timeout_o),
`ifdef EXEC_SEQ_PERF_CNT_EN
    .retired_cnt_o(retired_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [12:0] off, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [4:0] rd,
                                     input logic [3:0] op);
    return {off, ra, rb, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Offer an instruction in the current IDLE cycle; return in the first busy cycle.
  task automatic issue(input logic [31:0] ins);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    #1 chk("ready_before_accept", 32'(instr_ready_o), 32'd1);
    tick();
    instr_valid_i = 1'b0;
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] ret, input logic [31:0] stl);
`ifdef EXEC_SEQ_PERF_CNT_EN
    chk({tag, "_retired"}, retired_cnt_o, ret);
    chk({tag, "_stall"},   stall_cnt_o,   stl);
`else
    if (tag.len() == 0 && ret == stl) $display("unused");
`endif
  endtask

  initial begin
    rst_ni = 1'b0; instr_valid_i = 1'b0; instr_i = '0; mem_ack_i = 1'b0; br_taken_i = 1'b0;
    tick(); tick();
    #1;
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_outs", {alu_en_o, alu_op_o, ra_o, rb_o, rd_o, rf_we_o, mem_req_o, mem_we_o,
                     pc_load_o, illegal_o, timeout_o, busy_o}, 32'd0);
    chk("rst_offset", 32'(offset_o), 32'd0);
    chk_cnt("rst", 32'd0, 32'd0);
    rst_ni = 1'b1;
    tick();

    // ADD ra=1 rb=1 rd=3: one EXEC cycle, then ready again
    issue(mk(13'd0, 5'd1, 5'd1, 5'd3, 4'd0));
    chk("add_alu_en", 32'(alu_en_o), 32'd1);
    chk("add_rf_we",  32'(rf_we_o),  32'd1);
    chk("add_rd",     32'(rd_o),     32'd3);
    chk("add_ra",     32'(ra_o),     32'd1);
    chk("add_busy",   32'({instr_ready_o, busy_o}), 32'b01);
    tick(); #1;
    chk("add_done", 32'({instr_ready_o, rf_we_o, alu_en_o}), 32'b100);

    // MUL ra=6 rb=7 rd=8 with valid held for the whole MULDIV window
    issue(mk(13'd0, 5'd6, 5'd7, 5'd8, 4'd5));
    instr_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_alu_en_c%0d", k), 32'(alu_en_o), 32'd1);
      chk($sformatf("mul_rf_we_c%0d", k),  32'(rf_we_o),  32'(k == 4));
      if (k < 4) tick(); else begin @(posedge clk_i); instr_valid_i = 1'b0; #2; end
    end
    #1;
    chk("mul_done", 32'({instr_ready_o, alu_en_o, rd_o}), {24'd0, 1'b1, 1'b0, 5'd0});
    chk_cnt("mul", 32'd2, 32'd4);

    // LW offset=15 rb=4 rd=9: ack in the 3rd MEM cycle writes rd=rb
    issue(mk(13'd15, 5'd0, 5'd4, 5'd9, 4'd7));
    chk("lw_c1", 32'({mem_req_o, mem_we_o, rf_we_o}), 32'b100);
    chk("lw_offset", 32'(offset_o), 32'd15);
    tick(); #1;
    chk("lw_c2", 32'({mem_req_o, rf_we_o}), 32'b10);
    tick(); mem_ack_i = 1'b1; #1;
    chk("lw_ack", 32'({mem_req_o, rf_we_o}), 32'b11);
    chk("lw_rd",  32'(rd_o), 32'd4);
    tick(); mem_ack_i = 1'b0; #1;
    chk("lw_done", 32'({instr_ready_o, mem_req_o}), 32'b10);

    // SW offset=16 acked immediately: write flag, no register write
    issue(mk(13'd16, 5'd2, 5'd5, 5'd6, 4'd8));
    mem_ack_i = 1'b1; #1;
    chk("sw_ack", 32'({mem_req_o, mem_we_o, rf_we_o}), 32'b110);
    chk("sw_offset", 32'(offset_o), 32'd16);
    tick(); #1;
    // stray ack while IDLE is ignored
    chk("idle_ack", 32'({instr_ready_o, busy_o, rf_we_o, mem_req_o}), 32'b1000);
    tick(); mem_ack_i = 1'b0; #1;
    chk("idle_ack2", 32'(instr_ready_o), 32'd1);
    chk_cnt("mem", 32'd4, 32'd4);

    // LW never acked: timeout in the 15th MEM cycle, ready afterwards
    issue(mk(13'd3, 5'd0, 5'd2, 5'd1, 4'd7));
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("to_c%0d", k), 32'({mem_req_o, rf_we_o, timeout_o}), {29'd0, 1'b1, 1'b0, 1'(k == 15)});
      tick(); #1;
    end
    chk("to_done", 32'({instr_ready_o, mem_req_o, timeout_o}), 32'b100);
    chk_cnt("to", 32'd4, 32'd4);

    // LW acked in the final allowed cycle counts as success
    issue(mk(13'd3, 5'd0, 5'd2, 5'd1, 4'd7));
    for (int k = 1; k < 15; k++) tick();
    mem_ack_i = 1'b1; #1;
    chk("lastack", 32'({mem_req_o, rf_we_o, timeout_o}), 32'b110);
    tick(); mem_ack_i = 1'b0; #1;
    chk("lastack_done", 32'(instr_ready_o), 32'd1);

    // BEQ taken, then BGT not taken
    issue(mk(13'd15, 5'd1, 5'd2, 5'd0, 4'd9));
    br_taken_i = 1'b1; #1;
    chk("beq_pc_load", 32'(pc_load_o), 32'd1);
    tick(); #1;
    chk("beq_after", 32'({instr_ready_o, pc_load_o}), 32'b10);
    br_taken_i = 1'b0;
    issue(mk(13'd4, 5'd1, 5'd2, 5'd0, 4'd10));
    chk("bgt_pc_load", 32'({busy_o, pc_load_o}), 32'b10);
    tick();

    // Unassigned opcode 4'hF: one-cycle illegal pulse only
    issue(mk(13'd0, 5'd1, 5'd2, 5'd3, 4'hF));
    chk("ill_c1", 32'({illegal_o, alu_en_o, rf_we_o, busy_o}), 32'b1001);
    tick(); #1;
    chk("ill_done", 32'({illegal_o, instr_ready_o}), 32'b01);
    chk_cnt("br", 32'd7, 32'd4);

    // Reset in the 2nd MULDIV cycle aborts with everything cleared
    issue(mk(13'd0, 5'd6, 5'd7, 5'd8, 4'd6));
    tick(); rst_ni = 1'b0; #1;
    chk("rstmd_rf_we", 32'(rf_we_o), 32'd0);
    tick(); #1;
    chk("rstmd_ready", 32'({instr_ready_o, busy_o, alu_en_o, rf_we_o}), 32'b1000);
    chk("rstmd_fields", 32'({alu_op_o, ra_o, rb_o, rd_o, offset_o}), 32'd0);
    chk_cnt("rstmd", 32'd0, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Reset coinciding with a LW ack suppresses the register write
    issue(mk(13'd1, 5'd0, 5'd3, 5'd2, 4'd7));
    mem_ack_i = 1'b1; rst_ni = 1'b0; #1;
    chk("rstmem_rf_we", 32'({rf_we_o, timeout_o}), 32'b00);
    tick(); mem_ack_i = 1'b0; #1;
    chk("rstmem_ready", 32'({instr_ready_o, mem_req_o}), 32'b10);
    rst_ni = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
